// File: rtl/merger_tree_out_serializer.sv
// merger_tree_out_serializer: buffers wide tree-root beats in a small FIFO and
// serializes each one into bus beats (low slice first) for a counted run.
module merger_tree_out_serializer #(
    parameter int W     = 32,
    parameter int P     = 32,
    parameter int BUS_W = 512,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [31:0]      i_total_beats,
    input  logic             i_write,
    input  logic [P*W-1:0]   i_data,
    output logic             o_ready,
    output logic             o_bus_valid,
    output logic [BUS_W-1:0] o_bus_data,
    input  logic             i_bus_ready,
    output logic             o_done,
    output logic             o_overflow,
    output logic             o_extra
);
    localparam int IW    = P * W;
    localparam int RATIO = IW / BUS_W;
    localparam int AW    = $clog2(DEPTH);
    localparam int SW    = RATIO > 1 ? $clog2(RATIO) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [SW-1:0] sub;
    logic [31:0]   remaining;
    logic          overflow;
    logic          launch, push, accept, pop;

    assign launch      = i_start && state != RUN;
    assign o_ready     = state == RUN && count < (AW+1)'(DEPTH);
    assign o_bus_valid = state == RUN && count != '0;
    assign accept      = o_bus_valid && i_bus_ready;
    assign push        = i_write && o_ready;
    assign pop         = accept && 32'(sub) == RATIO - 1;
    assign o_bus_data  = o_bus_valid ? mem[rd_ptr][32'(sub)*BUS_W +: BUS_W] : '0;
    assign o_done      = state == DONE;
    assign o_extra     = state == DONE && count != '0;
    assign o_overflow  = overflow;

    always_comb begin
        state_nxt = state;
        if (launch)
            state_nxt = i_total_beats != '0 ? RUN : DONE;
        else if (accept && remaining == 32'd1)
            state_nxt = DONE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;

    // Leftovers from a finished run are discarded by the next launch.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            sub       <= '0;
            remaining <= '0;
            overflow  <= 1'b0;
        end else if (launch) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            sub       <= '0;
            remaining <= i_total_beats;
            overflow  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
            if (accept) begin
                remaining <= remaining - 1'b1;
                sub       <= pop ? '0 : sub + 1'b1;
            end
            if (i_write && !o_ready) overflow <= 1'b1;
        end
    end

    // Storage is data-only; validity comes from count, so it needs no reset.
    always_ff @(posedge i_clk)
        if (push) mem[wr_ptr] <= i_data;
endmodule

// File: tb/tb_merger_tree_out_serializer.sv
// tb_merger_tree_out_serializer: directed vector table for the basic run plus
// hand sequences for backpressure, overflow, zero/extra runs and async reset.
module tb_merger_tree_out_serializer;
    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [31:0]   total;
    logic          wr;
    logic [1023:0] data;
    logic          rdy;
    logic          bus_valid;
    logic [511:0]  bus_data;
    logic          bus_ready;
    logic          done;
    logic          ovf;
    logic          extra;

    int n_vec = 0;
    int n_bad = 0;

    merger_tree_out_serializer dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_total_beats(total),
        .i_write(wr), .i_data(data), .o_ready(rdy), .o_bus_valid(bus_valid),
        .o_bus_data(bus_data), .i_bus_ready(bus_ready), .o_done(done),
        .o_overflow(ovf), .o_extra(extra)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [31:0] total;
        logic        wr;
        int          wbase;
        logic        brdy;
        logic        e_rdy;
        logic        e_val;
        logic        e_done;
        int          ebase;
        int          eslice;
    } vec_t;

    vec_t tbl[7];

    function automatic logic [1023:0] beat(int base);
        logic [1023:0] b;
        for (int j = 0; j < 32; j++) b[j*32 +: 32] = 32'(base + j);
        return b;
    endfunction

    function automatic logic [511:0] slice(int base, int k);
        logic [1023:0] b;
        if (base < 0) return '0;
        b = beat(base);
        return b[k*512 +: 512];
    endfunction

    task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; start = 0; total = 0; wr = 0; data = '0; bus_ready = 0;
        tbl[0] = '{1, 4, 0, 0,   0, 0, 0, 0, -1,  0};
        tbl[1] = '{0, 0, 1, 0,   0, 1, 0, 0, -1,  0};
        tbl[2] = '{0, 0, 1, 100, 1, 1, 1, 0, 0,   0};
        tbl[3] = '{0, 0, 0, 0,   1, 1, 1, 0, 0,   1};
        tbl[4] = '{0, 0, 0, 0,   1, 1, 1, 0, 100, 0};
        tbl[5] = '{0, 0, 0, 0,   1, 1, 1, 0, 100, 1};
        tbl[6] = '{0, 0, 0, 0,   1, 0, 0, 1, -1,  0};
        tick();
        chk("rst_ready", rdy, 0);
        chk("rst_valid", bus_valid, 0);
        chk("rst_data", bus_data, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_extra", extra, 0);
        rst_n = 1'b1;
        tick();

        // basic run, one table row per cycle
        for (int i = 0; i < 7; i++) begin
            start = tbl[i].start; total = tbl[i].total; wr = tbl[i].wr;
            data = beat(tbl[i].wbase); bus_ready = tbl[i].brdy;
            chk($sformatf("basic%0d_ready", i), rdy, tbl[i].e_rdy);
            chk($sformatf("basic%0d_valid", i), bus_valid, tbl[i].e_val);
            chk($sformatf("basic%0d_done", i), done, tbl[i].e_done);
            chk($sformatf("basic%0d_data", i), bus_data, slice(tbl[i].ebase, tbl[i].eslice));
            tick();
        end
        start = 0; wr = 0; bus_ready = 0;

        // backpressure: fill four entries with the bus stalled
        do_reset();
        start = 1; total = 8;
        tick();
        start = 0;
        for (int i = 0; i < 4; i++) begin
            wr = 1; data = beat((i + 1) * 1000);
            chk($sformatf("fill%0d_ready", i), rdy, 1);
            tick();
        end
        wr = 0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("full%0d_ready", i), rdy, 0);
            chk($sformatf("full%0d_ovf", i), ovf, 0);
            chk($sformatf("full%0d_valid", i), bus_valid, 1);
            chk($sformatf("full%0d_data", i), bus_data, slice(1000, 0));
            tick();
        end
        bus_ready = 1;
        for (int b = 0; b < 8; b++) begin
            chk($sformatf("drain%0d_valid", b), bus_valid, 1);
            chk($sformatf("drain%0d_data", b), bus_data, slice((b / 2 + 1) * 1000, b % 2));
            tick();
        end
        chk("drain_done", done, 1);
        chk("drain_valid_after", bus_valid, 0);
        chk("drain_extra", extra, 0);
        bus_ready = 0;

        // overflow in IDLE, then a zero-length run clears it
        do_reset();
        wr = 1; data = beat(7);
        tick();
        wr = 0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("ovf%0d_flag", i), ovf, 1);
            chk($sformatf("ovf%0d_valid", i), bus_valid, 0);
            tick();
        end
        start = 1; total = 0;
        tick();
        start = 0;
        chk("zero_done", done, 1);
        chk("zero_valid", bus_valid, 0);
        chk("zero_ovf_cleared", ovf, 0);
        chk("zero_ready", rdy, 0);

        // one-beat run leaves half an entry behind
        start = 1; total = 1;
        tick();
        start = 0; wr = 1; data = beat(500);
        chk("extra_ready", rdy, 1);
        tick();
        wr = 0; bus_ready = 1;
        chk("extra_valid", bus_valid, 1);
        chk("extra_data", bus_data, slice(500, 0));
        tick();
        chk("extra_done", done, 1);
        chk("extra_flag", extra, 1);
        chk("extra_valid_after", bus_valid, 0);
        bus_ready = 0; start = 1; total = 0;
        tick();
        start = 0;
        chk("extra_cleared", extra, 0);
        chk("extra_done2", done, 1);

        // asynchronous reset with three entries buffered
        start = 1; total = 8;
        tick();
        start = 0;
        for (int i = 0; i < 3; i++) begin
            wr = 1; data = beat(2000 + i * 100);
            tick();
        end
        wr = 0;
        chk("pre_rst_valid", bus_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", bus_valid, 0);
        chk("arst_ready", rdy, 0);
        chk("arst_done", done, 0);
        chk("arst_data", bus_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", rdy, 0);
        chk("post_rst_valid", bus_valid, 0);
        chk("post_rst_done", done, 0);
        start = 1; total = 2;
        tick();
        start = 0;
        chk("post_rst_run_ready", rdy, 1);
        chk("post_rst_run_empty", bus_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
